// File: rtl/riscv_dp_lsu.sv
// Memory-stage load/store unit: one access per handshake, word-addressed bus with
// lane-aligned store data and byte enables; loads return the raw word plus offset/funct3.
module riscv_dp_lsu #(
    parameter int MP_DATA_WIDTH = 32,
    parameter int MP_TIMEOUT    = 16
) (
    input  logic                       iclk,
    input  logic                       irst_n,
    input  logic                       ivalid,
    output logic                       oready,
    input  logic                       iwe,
    input  logic [MP_DATA_WIDTH-1:0]   iaddr,
    input  logic [MP_DATA_WIDTH-1:0]   iwdata,
    input  logic [2:0]                 ifunct3,
    output logic                       omem_req,
    output logic                       omem_we,
    output logic [MP_DATA_WIDTH-1:0]   omem_addr,
    output logic [MP_DATA_WIDTH-1:0]   omem_wdata,
    output logic [MP_DATA_WIDTH/8-1:0] omem_be,
    input  logic                       imem_gnt,
    input  logic                       imem_rvalid,
    input  logic [MP_DATA_WIDTH-1:0]   imem_rdata,
    output logic [MP_DATA_WIDTH-1:0]   ordata,
    output logic [1:0]                 ooffset,
    output logic [2:0]                 ofunct3,
    output logic                       ordvalid,
    output logic                       odone,
    output logic                       omisalign,
    output logic                       otimeout
);
    localparam int         W        = MP_DATA_WIDTH;
    localparam int         NB       = W / 8;
    localparam logic [7:0] TMO_LAST = 8'(MP_TIMEOUT - 1);
    localparam logic [1:0] SZ_B     = 2'b00;
    localparam logic [1:0] SZ_H     = 2'b01;
    localparam logic [1:0] SZ_W     = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RWAIT,
        ST_RESP
    } state_t;

    state_t        state_reg, state_next;
    logic [7:0]    cnt_reg, cnt_next;

    logic [1:0]    offset;
    logic [1:0]    size;
    logic          misaligned;
    logic          accept;
    logic          launch;
    logic          rdata_capture;
    logic          done_next, misalign_next, timeout_next;
    logic [NB-1:0] be_calc;
    logic [W-1:0]  wdata_calc;

    logic          we_reg;
    logic [W-1:0]  addr_reg;
    logic [W-1:0]  wdata_reg;
    logic [NB-1:0] be_reg;
    logic [W-1:0]  rdata_reg;
    logic [1:0]    offset_reg;
    logic [2:0]    funct3_reg;
    logic          ready_reg;
    logic          done_reg, misalign_reg, timeout_reg;

    assign offset = iaddr[1:0];
    assign size   = ifunct3[1:0];
    assign accept = ivalid & ready_reg;
    assign launch = accept & ~misaligned;

    // Size code 11 has no legal RV32 access, so it is rejected like a misalignment.
    always_comb begin
        misaligned = 1'b1;
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = (offset == 2'd3);
            SZ_W:    misaligned = (offset != 2'd0);
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        be_calc = '1;
        if (iwe) begin
            case (size)
                SZ_B:    be_calc = NB'(1) << offset;
                SZ_H:    be_calc = NB'(3) << offset;
                default: be_calc = '1;
            endcase
        end
    end

    // Per-lane store data; a halfword's low byte lands on the lane matching the offset parity.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            localparam bit LANE_ODD = (gi % 2) == 1;
            logic [7:0] lane_byte;

            always_comb begin
                lane_byte = 8'h00;
                if (iwe) begin
                    case (size)
                        SZ_B: lane_byte = iwdata[7:0];
                        SZ_H: begin
                            if (be_calc[gi]) begin
                                lane_byte = (LANE_ODD ^ offset[0]) ? iwdata[15:8] : iwdata[7:0];
                            end
                        end
                        default: lane_byte = iwdata[gi*8 +: 8];
                    endcase
                end
            end

            assign wdata_calc[gi*8 +: 8] = lane_byte;
        end
    endgenerate

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Bus responses on the expiring cycle are checked before the timeout.
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        done_next     = 1'b0;
        misalign_next = 1'b0;
        timeout_next  = 1'b0;
        rdata_capture = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        misalign_next = 1'b1;
                    end else begin
                        state_next = ST_REQ;
                        cnt_next   = '0;
                    end
                end
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    if (we_reg) begin
                        done_next  = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        state_next = ST_RWAIT;
                        cnt_next   = '0;
                    end
                end else if (cnt_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_RWAIT: begin
                if (imem_rvalid) begin
                    rdata_capture = 1'b1;
                    state_next    = ST_RESP;
                end else if (cnt_reg == TMO_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            be_reg       <= '0;
            rdata_reg    <= '0;
            offset_reg   <= '0;
            funct3_reg   <= '0;
            ready_reg    <= 1'b0;
            done_reg     <= 1'b0;
            misalign_reg <= 1'b0;
            timeout_reg  <= 1'b0;
        end else begin
            ready_reg    <= (state_next == ST_IDLE);
            done_reg     <= done_next;
            misalign_reg <= misalign_next;
            timeout_reg  <= timeout_next;
            if (launch) begin
                we_reg    <= iwe;
                addr_reg  <= {iaddr[W-1:2], 2'b00};
                wdata_reg <= wdata_calc;
                be_reg    <= be_calc;
                if (!iwe) begin
                    offset_reg <= offset;
                    funct3_reg <= ifunct3;
                end
            end
            if (rdata_capture) begin
                rdata_reg <= imem_rdata;
            end
        end
    end

    assign oready     = ready_reg;
    assign omem_req   = (state_reg == ST_REQ);
    assign omem_we    = we_reg;
    assign omem_addr  = addr_reg;
    assign omem_wdata = wdata_reg;
    assign omem_be    = be_reg;
    assign ordata     = rdata_reg;
    assign ooffset    = offset_reg;
    assign ofunct3    = funct3_reg;
    assign ordvalid   = (state_reg == ST_RESP);
    assign odone      = done_reg;
    assign omisalign  = misalign_reg;
    assign otimeout   = timeout_reg;

endmodule

// File: tb/tb_riscv_dp_lsu.sv
// Bench for riscv_dp_lsu: table of directed vectors, reset/stray-response sequences,
// and random accesses against a cycle-count model derived from the access rules.
module tb_riscv_dp_lsu;
    localparam int T      = 4;
    localparam int WINDOW = 14;
    localparam int K_DONE = 0;
    localparam int K_RD   = 1;
    localparam int K_MIS  = 2;
    localparam int K_TMO  = 3;
    localparam int NVEC   = 13;

    logic        iclk = 1'b0;
    logic        irst_n;
    logic        ivalid;
    logic        oready;
    logic        iwe;
    logic [31:0] iaddr;
    logic [31:0] iwdata;
    logic [2:0]  ifunct3;
    logic        omem_req;
    logic        omem_we;
    logic [31:0] omem_addr;
    logic [31:0] omem_wdata;
    logic [3:0]  omem_be;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ordata;
    logic [1:0]  ooffset;
    logic [2:0]  ofunct3;
    logic        ordvalid;
    logic        odone;
    logic        omisalign;
    logic        otimeout;

    always #5 iclk = ~iclk;

    riscv_dp_lsu #(
        .MP_DATA_WIDTH(32),
        .MP_TIMEOUT   (T)
    ) dut (
        .iclk       (iclk),
        .irst_n     (irst_n),
        .ivalid     (ivalid),
        .oready     (oready),
        .iwe        (iwe),
        .iaddr      (iaddr),
        .iwdata     (iwdata),
        .ifunct3    (ifunct3),
        .omem_req   (omem_req),
        .omem_we    (omem_we),
        .omem_addr  (omem_addr),
        .omem_wdata (omem_wdata),
        .omem_be    (omem_be),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .ordata     (ordata),
        .ooffset    (ooffset),
        .ofunct3    (ofunct3),
        .ordvalid   (ordvalid),
        .odone      (odone),
        .omisalign  (omisalign),
        .otimeout   (otimeout)
    );

    // g = REQ cycles without grant before the grant, r = idle cycles after grant before rvalid
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        int          g;
        int          r;
        logic [31:0] rdata;
    } txn_t;

    // at = sample index (after accept) of the ending pulse; busy/reqs = samples with oready low / req high
    typedef struct {
        int          kind;
        int          at;
        int          busy;
        int          reqs;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
    } exp_t;

    typedef struct {
        txn_t t;
        exp_t e;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ob_first[4];
    int          ob_cnt[4];
    int          ob_busy;
    int          ob_reqs;
    logic        ob_we;
    logic [31:0] ob_maddr;
    logic [31:0] ob_mwdata;
    logic [31:0] ob_rd;
    logic [3:0]  ob_be;
    logic [1:0]  ob_off;
    logic [2:0]  ob_f3;
    vec_t        vecs[NVEC];

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s [txn %0d]: got 0x%08h expected 0x%08h", name, id, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [2:0] f3, input int g, input int r, input logic [31:0] rdata,
                                input int kind, input int at, input int busy, input int reqs,
                                input logic [31:0] maddr, input logic [3:0] be, input logic [31:0] mwdata);
        vec_t v;
        v.t.we = we;      v.t.addr = addr;   v.t.wdata = wdata; v.t.f3 = f3;
        v.t.g = g;        v.t.r = r;         v.t.rdata = rdata;
        v.e.kind = kind;  v.e.at = at;       v.e.busy = busy;   v.e.reqs = reqs;
        v.e.maddr = maddr; v.e.be = be;      v.e.mwdata = mwdata;
        return v;
    endfunction

    function automatic exp_t model(input txn_t t);
        exp_t       e;
        int         sz;
        int         o;
        logic [1:0] osel;
        sz   = int'(t.f3[1:0]);
        o    = int'(t.addr[1:0]);
        osel = t.addr[1:0];
        e.maddr  = t.addr & 32'hFFFF_FFFC;
        e.be     = 4'hF;
        e.mwdata = 32'h0;
        if (t.we) begin
            if (sz == 0) begin
                e.be     = 4'(4'b0001 << osel);
                e.mwdata = 32'(t.wdata[7:0]) * 32'h0101_0101;
            end else if (sz == 1) begin
                e.be     = 4'(4'b0011 << osel);
                e.mwdata = {16'h0, t.wdata[15:0]} << (8 * o);
            end else begin
                e.mwdata = t.wdata;
            end
        end
        if (sz == 3 || (sz == 1 && o == 3) || (sz == 2 && o != 0)) begin
            e.kind = K_MIS; e.at = 1; e.busy = 0; e.reqs = 0;
        end else if (t.g >= T) begin
            e.kind = K_TMO; e.at = T + 1; e.busy = T; e.reqs = T;
        end else if (t.we) begin
            e.kind = K_DONE; e.at = t.g + 2; e.busy = t.g + 1; e.reqs = t.g + 1;
        end else if (t.r >= T) begin
            e.kind = K_TMO; e.at = t.g + 2 + T; e.busy = t.g + 1 + T; e.reqs = t.g + 1;
        end else begin
            e.kind = K_RD; e.at = t.g + t.r + 3; e.busy = t.g + t.r + 3; e.reqs = t.g + 1;
        end
        return e;
    endfunction

    // Presents one access at the current negedge, then acts as a reactive bus for WINDOW cycles.
    task automatic run_txn(input txn_t t);
        int req_seen;
        int wait_cnt;
        bit gnt_done;
        logic [3:0] pulses;
        for (int k = 0; k < 4; k++) begin
            ob_first[k] = -1;
            ob_cnt[k]   = 0;
        end
        ob_busy = 0; ob_reqs = 0; ob_we = 1'b0;
        ob_maddr = '0; ob_mwdata = '0; ob_be = '0; ob_rd = '0; ob_off = '0; ob_f3 = '0;
        req_seen = 0; wait_cnt = 0; gnt_done = 1'b0;
        ivalid = 1'b1; iwe = t.we; iaddr = t.addr; iwdata = t.wdata; ifunct3 = t.f3;
        for (int s = 1; s <= WINDOW; s++) begin
            @(negedge iclk);
            pulses = {otimeout, omisalign, ordvalid, odone};
            for (int k = 0; k < 4; k++) begin
                if (pulses[k]) begin
                    if (ob_first[k] < 0) ob_first[k] = s;
                    ob_cnt[k]++;
                end
            end
            if (!oready) ob_busy++;
            if (ordvalid) begin
                ob_rd = ordata; ob_off = ooffset; ob_f3 = ofunct3;
            end
            ivalid = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
            if (omem_req) begin
                if (ob_reqs == 0) begin
                    ob_maddr = omem_addr; ob_be = omem_be; ob_mwdata = omem_wdata; ob_we = omem_we;
                end
                ob_reqs++;
                if (req_seen == t.g) begin
                    imem_gnt = 1'b1;
                    gnt_done = 1'b1;
                end
                req_seen++;
            end else if (gnt_done) begin
                if (wait_cnt == t.r) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = t.rdata;
                end
                wait_cnt++;
            end
        end
    endtask

    task automatic check_txn(input int id, input txn_t t, input exp_t e);
        $display("txn %0d: we=%0b addr=%08h f3=%03b g=%0d r=%0d expect kind=%0d at=%0d busy=%0d",
                 id, t.we, t.addr, t.f3, t.g, t.r, e.kind, e.at, e.busy);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("pulse_count_k%0d", k), id, 32'(ob_cnt[k]), (k == e.kind) ? 32'd1 : 32'd0);
        end
        chk("pulse_cycle", id, 32'(ob_first[e.kind]), 32'(e.at));
        chk("busy_cycles", id, 32'(ob_busy), 32'(e.busy));
        chk("req_cycles", id, 32'(ob_reqs), 32'(e.reqs));
        if (e.reqs > 0) begin
            chk("mem_addr", id, ob_maddr, e.maddr);
            chk("mem_be", id, 32'(ob_be), 32'(e.be));
            chk("mem_wdata", id, ob_mwdata, e.mwdata);
            chk("mem_we", id, 32'(ob_we), 32'(t.we));
        end
        if (e.kind == K_RD) begin
            chk("rdata", id, ob_rd, t.rdata);
            chk("offset", id, 32'(ob_off), 32'(t.addr[1:0]));
            chk("funct3", id, 32'(ob_f3), 32'(t.f3));
            chk("rdata_hold", id, ordata, t.rdata);
        end
        chk("ready_after", id, 32'(oready), 32'd1);
    endtask

    initial begin
        txn_t t;
        irst_n = 1'b0; ivalid = 1'b0; iwe = 1'b0; iaddr = '0; iwdata = '0; ifunct3 = '0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

        vecs[0]  = mk(1, 32'h0000_1003, 32'h0000_00A5, 3'b000, 0, 0, 32'h0, K_DONE, 2, 1, 1, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        vecs[1]  = mk(0, 32'h0000_2002, 32'h0, 3'b001, 2, 0, 32'h8001_1234, K_RD, 5, 5, 3, 32'h0000_2000, 4'hF, 32'h0);
        vecs[2]  = mk(1, 32'h0000_0002, 32'h1122_3344, 3'b010, 0, 0, 32'h0, K_MIS, 1, 0, 0, 32'h0, 4'h0, 32'h0);
        vecs[3]  = mk(0, 32'h0000_0003, 32'h0, 3'b001, 0, 0, 32'h0, K_MIS, 1, 0, 0, 32'h0, 4'h0, 32'h0);
        vecs[4]  = mk(0, 32'h0000_4000, 32'h0, 3'b010, 4, 0, 32'h0, K_TMO, 5, 4, 4, 32'h0000_4000, 4'hF, 32'h0);
        vecs[5]  = mk(1, 32'h0000_3004, 32'h1234_5678, 3'b010, 3, 0, 32'h0, K_DONE, 5, 4, 4, 32'h0000_3004, 4'hF, 32'h1234_5678);
        vecs[6]  = mk(1, 32'h0000_5001, 32'hCAFE_BEEF, 3'b001, 1, 0, 32'h0, K_DONE, 3, 2, 2, 32'h0000_5000, 4'b0110, 32'h00BE_EF00);
        vecs[7]  = mk(0, 32'h0000_6001, 32'h0, 3'b100, 0, 3, 32'hA1B2_C3D4, K_RD, 6, 6, 1, 32'h0000_6000, 4'hF, 32'h0);
        vecs[8]  = mk(0, 32'h0000_7000, 32'h0, 3'b101, 1, 4, 32'h5A5A_0000, K_TMO, 7, 6, 2, 32'h0000_7000, 4'hF, 32'h0);
        vecs[9]  = mk(0, 32'h0000_8000, 32'h0, 3'b011, 0, 0, 32'h0, K_MIS, 1, 0, 0, 32'h0, 4'h0, 32'h0);
        vecs[10] = mk(1, 32'h0000_9002, 32'h1234_567E, 3'b000, 0, 0, 32'h0, K_DONE, 2, 1, 1, 32'h0000_9000, 4'b0100, 32'h7E7E_7E7E);
        vecs[11] = mk(1, 32'h0000_A002, 32'h9876_ABCD, 3'b001, 0, 0, 32'h0, K_DONE, 2, 1, 1, 32'h0000_A000, 4'b1100, 32'hABCD_0000);
        vecs[12] = mk(0, 32'h0000_B003, 32'h0, 3'b000, 0, 1, 32'h0102_0304, K_RD, 4, 4, 1, 32'h0000_B000, 4'hF, 32'h0);

        repeat (2) @(negedge iclk);
        chk("rst_oready", -1, 32'(oready), 32'd0);
        chk("rst_req", -1, 32'(omem_req), 32'd0);
        chk("rst_be", -1, 32'(omem_be), 32'd0);
        chk("rst_addr", -1, omem_addr, 32'd0);
        chk("rst_pulses", -1, 32'({odone, ordvalid, omisalign, otimeout}), 32'd0);
        irst_n = 1'b1;
        @(negedge iclk);
        chk("ready_after_rst", -1, 32'(oready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_txn(vecs[i].t);
            check_txn(i, vecs[i].t, vecs[i].e);
        end

        // Stray read data after a grant timeout must not produce a response.
        t = vecs[4].t;
        t.g = 9;
        run_txn(t);
        check_txn(50, t, model(t));
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h5555_5555;
        for (int s = 0; s < 3; s++) begin
            @(negedge iclk);
            imem_rvalid = 1'b0;
            chk("stray_no_rdvalid", 51, 32'(ordvalid), 32'd0);
            chk("stray_ready", 51, 32'(oready), 32'd1);
        end

        // Reset while requesting: request drops without waiting for a clock edge.
        ivalid = 1'b1; iwe = 1'b0; iaddr = 32'h0000_0100; ifunct3 = 3'b010;
        @(negedge iclk);
        ivalid = 1'b0;
        chk("req_before_rst", 52, 32'(omem_req), 32'd1);
        irst_n = 1'b0;
        #1;
        chk("rst_req_drop", 52, 32'(omem_req), 32'd0);
        chk("rst_req_ready", 52, 32'(oready), 32'd0);
        chk("rst_req_addr", 52, omem_addr, 32'd0);
        @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        chk("ready_after_rst2", 52, 32'(oready), 32'd1);

        // Reset while waiting for read data: transaction is lost, no pulse.
        ivalid = 1'b1; iwe = 1'b0; iaddr = 32'h0000_0200; ifunct3 = 3'b010;
        @(negedge iclk);
        ivalid = 1'b0;
        imem_gnt = omem_req;
        @(negedge iclk);
        imem_gnt = 1'b0;
        chk("rwait_req_low", 53, 32'(omem_req), 32'd0);
        chk("rwait_busy", 53, 32'(oready), 32'd1 - 32'd1);
        irst_n = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h7777_7777;
        #1;
        chk("rst_rwait_ready", 53, 32'(oready), 32'd0);
        chk("rst_rwait_rdvalid", 53, 32'(ordvalid), 32'd0);
        chk("rst_rwait_rdata", 53, ordata, 32'd0);
        @(negedge iclk);
        imem_rvalid = 1'b0;
        irst_n = 1'b1;
        @(negedge iclk);
        chk("post_rst_rdvalid", 53, 32'(ordvalid), 32'd0);
        chk("post_rst_ready", 53, 32'(oready), 32'd1);
        t = vecs[5].t;
        t.addr = 32'h0000_0010; t.wdata = 32'hDEAD_BEEF; t.g = 0;
        run_txn(t);
        check_txn(54, t, model(t));

        for (int i = 0; i < 40; i++) begin
            t.we    = 1'($urandom_range(0, 1));
            t.addr  = $urandom;
            t.wdata = $urandom;
            t.f3    = 3'($urandom_range(0, 7));
            t.g     = int'($urandom_range(0, 5));
            t.r     = int'($urandom_range(0, 5));
            t.rdata = $urandom;
            run_txn(t);
            check_txn(100 + i, t, model(t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_dp_lsu.md
Name: riscv_dp_lsu

Overview:
- Load/store unit in the memory stage of the datapath.
- Accepts one load or store per handshake from the pipeline and drives the word-addressed data-memory bus, including byte enables and lane-aligned store data.
- Holds the pipeline while the access is in flight.
- For loads, returns the raw 32-bit word with the latched byte offset and funct3; these feed the load decoder's idata/iop/ifunct3 directly.

Parameters:
- MP_DATA_WIDTH, 32, data and address width (only 32 supported).
- MP_TIMEOUT, 16, max cycles spent waiting on grant or read data before abort; range 2..255.

Ports:
- iclk  input  1  clock, rising edge.
- irst_n  input  1  asynchronous reset, active-low.
- ivalid  input  1  pipeline presents an access.
- oready  output  1  LSU can accept (IDLE only).
- iwe  input  1  1 = store, 0 = load.
- iaddr  input  32  byte address.
- iwdata  input  32  store data, right-justified.
- ifunct3  input  3  RISC-V funct3 (size/sign).
- omem_req  output  1  bus request.
- omem_we  output  1  bus write.
- omem_addr  output  32  word address, {iaddr[31:2],2'b00}.
- omem_wdata  output  32  lane-aligned store data.
- omem_be  output  4  byte enables.
- imem_gnt  input  1  bus accepts request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  32  read word.
- ordata  output  32  captured raw word (to load decoder idata).
- ooffset  output  2  captured iaddr[1:0] (to load decoder iop).
- ofunct3  output  3  captured funct3 (to load decoder ifunct3).
- ordvalid  output  1  one-cycle pulse: load data valid.
- odone  output  1  one-cycle pulse: store granted.
- omisalign  output  1  one-cycle pulse: misaligned access rejected.
- otimeout  output  1  one-cycle pulse: bus timeout abort.

Behaviour:
- Clock/reset: one clock domain, iclk. Reset is asynchronous, active-low on irst_n. All state and outputs clear immediately on assertion: state=IDLE, oready=1 (once reset released), all other outputs 0. Reset mid-operation drops omem_req in the same instant; the transaction is lost and no pulse is issued.
- FSM states: IDLE, REQ, RWAIT, RESP.
- IDLE:
  - oready=1. Accept when ivalid&oready; latch iwe, iaddr, iwdata, ifunct3.
  - Misaligned means: size=half (funct3[1:0]=01) with offset 3, or size=word (10) with offset≠0. The decoder's halfword wrap case at offset 3 is therefore never issued.
  - On a misaligned accept, pulse omisalign next cycle and stay IDLE; no bus request.
  - funct3[1:0]=11 is treated as misaligned.
  - Otherwise go to REQ.
- REQ:
  - omem_req=1. omem_we, omem_addr, omem_wdata and omem_be are stable and registered.
  - On imem_gnt: a store pulses odone next cycle and returns to IDLE; a load goes to RWAIT.
- RWAIT:
  - omem_req=0.
  - On imem_rvalid: capture ordata=imem_rdata, go to RESP.
  - imem_rvalid in the same cycle as gnt is not allowed; the bus has minimum 1-cycle read latency.
- RESP: ordvalid=1 for exactly one cycle, then IDLE. ordata, ooffset and ofunct3 hold their values until the next load is accepted.
- Timeout: an 8-bit counter clears on entry to REQ and RWAIT and increments each cycle in those states. When it reaches MP_TIMEOUT-1 without gnt/rvalid, pulse otimeout, drop omem_req, return to IDLE.
  - A gnt or rvalid on the expiring cycle wins over the timeout.
  - A late imem_rvalid arriving in IDLE is ignored.
- Byte enables and data, by offset o=iaddr[1:0]:
  - sb: be=4'b0001<<o; wdata = byte replicated on all 4 lanes.
  - sh: be=4'b0011<<o for o∈{0,1,2}; wdata = {halfword at bits [8o+15:8o]}, other lanes 0.
  - sw: be=4'b1111, wdata=iwdata.
  - Loads: be=4'b1111, wdata=0.
- Throughput and latency:
  - Store: 2 cycles accept→odone with immediate grant.
  - Load: 3 cycles accept→ordvalid with gnt in the first REQ cycle and rvalid one cycle later.
  - No back-to-back accept: oready is low from accept until return to IDLE.

Test Plan:
- Store byte: iaddr=0x1003, sb, iwdata=0x000000A5, gnt immediate → omem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, odone pulse at cycle 2.
- Load half, offset 2: iaddr=0x2002, lh, gnt after 3 cycles, rvalid=0x8001_1234 one cycle later → ordata=0x80011234, ooffset=2, ofunct3=001, ordvalid single pulse; oready low throughout.
- Misaligned: sw at 0x0002, then lh at 0x0003 → omisalign pulse for each, omem_req never asserted, oready returns to 1.
- Timeout: MP_TIMEOUT=4, load with gnt never asserted → otimeout at 4th REQ cycle, FSM in IDLE; a later stray rvalid produces no ordvalid.
- Reset mid-load: assert irst_n=0 during RWAIT → omem_req, ordvalid, oready go 0 asynchronously. After release, a new sw at 0x10 with wdata 0xDEADBEEF completes with be=1111.
- Boundary race: gnt and timeout expiry on the same cycle → grant wins; store completes with odone and no otimeout.
